// File: rtl/seq_checker.sv
// Receive-side checker for the thermometer fill/drain sequence.
// Hunts for a unique non-extreme word, then flywheels through the period and flags mismatches.
module seq_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MISS_LIMIT = 3,
  localparam int unsigned PW        = $clog2(2 * WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             match,
  output logic             error,
  output logic [PW-1:0]    pos,
  output logic [15:0]      err_count
);

  localparam int PI = 2 * int'(WIDTH) + 2;
  localparam int WI = int'(WIDTH);
  localparam int unsigned MW = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT + 1);
  localparam logic [PW-1:0] PLast = PW'(PI - 1);

  typedef enum logic [0:0] {StHunt, StLock} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [MW-1:0]     miss_q, miss_d;
  logic [15:0]       err_count_q, err_count_d;
  logic              match_q, match_d;
  logic              error_q, error_d;

  logic [PW-1:0]     pos_next;
  logic [WIDTH-1:0]  exp_word;
  logic              lsb_ok, msb_ok, hunt_ok;
  logic [PW-1:0]     hunt_idx;

  function automatic logic [WIDTH-1:0] ref_word(input logic [PW-1:0] idx);
    logic [WIDTH-1:0] w;
    int i;
    i = int'(idx);
    w = '0;
    for (int b = 0; b < WI; b++) begin
      if (i <= 1)           w[b] = 1'b0;
      else if (i <= WI)     w[b] = (b < i - 1);
      else if (i <= WI + 2) w[b] = 1'b1;
      else                  w[b] = (b >= WI - (PI - i));
    end
    return w;
  endfunction

  function automatic int ones_of(input logic [WIDTH-1:0] w);
    int n;
    n = 0;
    for (int b = 0; b < WI; b++) n += int'(w[b]);
    return n;
  endfunction

  assign pos_next = (pos_q == PLast) ? '0 : pos_q + PW'(1);
  assign exp_word = ref_word(pos_next);

  // A run of ones anchored at either end; the extremes are excluded because they repeat.
  assign lsb_ok   = (in_data & (in_data + WIDTH'(1))) == '0;
  assign msb_ok   = (~in_data & (~in_data + WIDTH'(1))) == '0;
  assign hunt_ok  = (in_data != '0) && (in_data != '1) && (lsb_ok || msb_ok);
  assign hunt_idx = lsb_ok ? PW'(ones_of(in_data) + 1) : PW'(PI - ones_of(in_data));

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    miss_d      = miss_q;
    err_count_d = err_count_q;
    match_d     = 1'b0;
    error_d     = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        StHunt: begin
          if (hunt_ok) begin
            state_d = StLock;
            pos_d   = hunt_idx;
            match_d = 1'b1;
            miss_d  = '0;
          end
        end
        StLock: begin
          pos_d = pos_next;
          if (in_data == exp_word) begin
            match_d = 1'b1;
            miss_d  = '0;
          end else begin
            error_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (miss_q + MW'(1) == MW'(MISS_LIMIT)) begin
              state_d = StHunt;
              pos_d   = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MW'(1);
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHunt;
      pos_q       <= '0;
      miss_q      <= '0;
      err_count_q <= '0;
      match_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      miss_q      <= miss_d;
      err_count_q <= err_count_d;
      match_q     <= match_d;
      error_q     <= error_d;
    end
  end

  assign locked    = (state_q == StLock);
  assign match     = match_q;
  assign error     = error_q;
  assign pos       = pos_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_seq_checker.sv
// Bench for seq_checker: a sequence-table model checked every cycle, plus directed literal checks.
module tb_seq_checker;

  localparam int W  = 8;
  localparam int ML = 3;
  localparam int P  = 2 * W + 2;
  localparam int PW = $clog2(2 * W + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          locked, match, error;
  logic [PW-1:0] pos;
  logic [15:0]   err_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] rw [P];

  // Model state
  int m_locked = 0, m_pos = 0, m_miss = 0, m_err = 0, m_match = 0, m_error = 0;

  seq_checker #(.WIDTH(W), .MISS_LIMIT(ML)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .locked    (locked),
    .match     (match),
    .error     (error),
    .pos       (pos),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_locked = 0; m_pos = 0; m_miss = 0; m_err = 0; m_match = 0; m_error = 0;
    end else begin
      m_match = 0;
      m_error = 0;
      if (in_valid === 1'b1) begin
        if (m_locked == 0) begin
          if (in_data != '0 && in_data != '1) begin
            for (int i = 0; i < P; i++) begin
              if (m_locked == 0 && rw[i] == in_data) begin
                m_locked = 1; m_pos = i; m_match = 1; m_miss = 0;
              end
            end
          end
        end else begin
          m_pos = (m_pos + 1) % P;
          if (in_data == rw[m_pos]) begin
            m_match = 1; m_miss = 0;
          end else begin
            m_error = 1;
            if (m_err < 65535) m_err++;
            m_miss++;
            if (m_miss == ML) begin
              m_locked = 0; m_pos = 0; m_miss = 0;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("cyc_locked", int'(locked), m_locked);
      chk("cyc_match", int'(match), m_match);
      chk("cyc_error", int'(error), m_error);
      chk("cyc_pos", int'(pos), m_pos);
      chk("cyc_err_count", int'(err_count), m_err);
    end
  end

  task automatic send(input logic v, input logic [W-1:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < P; i++) begin
      if (i <= 1)          rw[i] = '0;
      else if (i <= W)     rw[i] = W'((1 << (i - 1)) - 1);
      else if (i <= W + 2) rw[i] = '1;
      else                 rw[i] = W'(((1 << (P - i)) - 1) << (W - (P - i)));
    end
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_locked", int'(locked), 0);
    chk("reset_err_count", int'(err_count), 0);
    chk("tbl_13", int'(rw[13]), 'hF8);
    chk("tbl_3", int'(rw[3]), 'h03);

    // Clean stream from index 0
    send(1'b1, rw[0]); send(1'b1, rw[1]);
    chk("t1_no_lock_on_zero", int'(locked), 0);
    send(1'b1, rw[2]);
    chk("t1_lock", int'(locked), 1);
    chk("t1_pos", int'(pos), 2);
    chk("t1_match", int'(match), 1);
    for (int k = 0; k < 36; k++) send(1'b1, rw[(3 + k) % P]);
    chk("t1_pos_end", int'(pos), 2);
    chk("t1_errs", int'(err_count), 0);

    // Single corruption
    send(1'b1, 8'h03); send(1'b1, 8'h07);
    send(1'b1, 8'h0E);
    chk("t3_error", int'(error), 1);
    chk("t3_errs", int'(err_count), 1);
    chk("t3_locked", int'(locked), 1);
    send(1'b1, 8'h1F);
    chk("t3_match", int'(match), 1);
    chk("t3_pos", int'(pos), 6);

    // Valid gaps hold state
    repeat (5) send(1'b0, 8'h3F);
    chk("t5_pos_hold", int'(pos), 6);
    chk("t5_no_match", int'(match), 0);

    // Loss of lock
    send(1'b1, 8'h55); send(1'b1, 8'h55);
    chk("t4_still_locked", int'(locked), 1);
    send(1'b1, 8'h55);
    chk("t4_error3", int'(error), 1);
    chk("t4_dropped", int'(locked), 0);
    chk("t4_pos0", int'(pos), 0);
    chk("t4_errs", int'(err_count), 4);
    send(1'b1, 8'hFF);
    chk("t4_ff_ignored", int'(locked), 0);
    send(1'b1, 8'hFE);
    chk("t4_relock", int'(locked), 1);
    chk("t4_relock_pos", int'(pos), 11);

    // Reset mid-operation
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("t6_locked", int'(locked), 0);
    chk("t6_pos", int'(pos), 0);
    chk("t6_errs", int'(err_count), 0);
    chk("t6_match", int'(match), 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // HUNT filtering
    send(1'b1, 8'h55); send(1'b1, 8'h00); send(1'b1, 8'hFF);
    chk("t5_hunt_nolock", int'(locked), 0);
    chk("t5_hunt_errs", int'(err_count), 0);

    // Mid-period acquisition
    send(1'b1, 8'hF8);
    chk("t2_locked", int'(locked), 1);
    chk("t2_pos", int'(pos), 13);
    chk("t2_model_pos", m_pos, 13);
    send(1'b1, 8'hF0);
    chk("t2_pos14", int'(pos), 14);
    chk("t2_match", int'(match), 1);
    for (int k = 0; k < 6; k++) send(1'b1, rw[(15 + k) % P]);
    chk("t2_wrap_pos", int'(pos), 2);
    send(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
